// File: rtl/loopback_tester.sv
// rtl/loopback_tester.sv - pin-loopback self-test pattern engine with sticky per-channel fail mask
// Optional PRBS-7 vector tail is compiled in when LOOPBACK_PRBS_EN is defined.
module loopback_tester #(
  parameter int N_CH   = 8,
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_CH-1:0] drive_o,
  input  logic [N_CH-1:0] sense_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_CH-1:0] fail_mask,
  output logic [15:0]     err_count
);

  // Two synchronizer stages plus one compare edge need at least three cycles of hold.
  localparam int S_EFF = (SETTLE < 3) ? 3 : SETTLE;
`ifdef LOOPBACK_PRBS_EN
  localparam int N_VEC = 2 * N_CH + 66;
`else
  localparam int N_VEC = 2 * N_CH + 2;
`endif
  localparam int CW = $clog2(S_EFF + 1);
  localparam logic [CW-1:0] CMP_AT  = CW'(S_EFF - 1);
  localparam logic [CW-1:0] LOAD_AT = CW'(S_EFF);
  localparam logic [7:0]    LAST    = 8'(N_VEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state;
  logic [7:0]        vidx;
  logic [7:0]        vidx_nxt;
  logic [CW-1:0]     cnt;
  logic [N_CH-1:0]   sense_meta;
  logic [N_CH-1:0]   sense_sync;
  logic [N_CH-1:0]   mism;
  logic [N_CH-1:0]   next_vec;

  function automatic logic [N_CH-1:0] pattern(input logic [7:0] idx);
    int i;
    i = int'(idx);
    if (i < N_CH)
      pattern = N_CH'(1) << i;
    else if (i < 2 * N_CH)
      pattern = ~(N_CH'(1) << (i - N_CH));
    else if (i == 2 * N_CH)
      pattern = '0;
    else
      pattern = '1;
  endfunction

  assign vidx_nxt = vidx + 8'd1;
  assign mism     = drive_o ^ sense_sync;

`ifdef LOOPBACK_PRBS_EN
  localparam logic [7:0] PRBS_BASE = 8'(2 * N_CH + 2);
  logic [6:0]      lfsr;
  logic [6:0]      lfsr_adv;
  logic [N_CH-1:0] prbs_vec;

  // Each channel takes one successive LFSR output bit, so the LFSR advances N_CH steps per vector.
  always_comb begin
    lfsr_adv = lfsr;
    prbs_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      prbs_vec[i] = lfsr_adv[6] ^ lfsr_adv[5];
      lfsr_adv    = {lfsr_adv[5:0], prbs_vec[i]};
    end
  end

  always_comb begin
    next_vec = pattern(vidx_nxt);
    if (vidx_nxt >= PRBS_BASE) next_vec = prbs_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 7'h7F;
    end else if (state != RUN && start) begin
      lfsr <= 7'h7F;
    end else if (state == RUN && cnt == LOAD_AT && vidx != LAST && vidx_nxt >= PRBS_BASE) begin
      lfsr <= lfsr_adv;
    end
  end
`else
  always_comb begin
    next_vec = pattern(vidx_nxt);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sense_meta <= '0;
      sense_sync <= '0;
    end else begin
      sense_meta <= sense_i;
      sense_sync <= sense_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vidx      <= '0;
      cnt       <= '0;
      drive_o   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      err_count <= '0;
    end else begin
      case (state)
        IDLE, FIN: begin
          if (start) begin
            state     <= RUN;
            vidx      <= '0;
            cnt       <= '0;
            drive_o   <= pattern(8'd0);
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_mask <= '0;
            err_count <= '0;
          end
        end
        RUN: begin
          if (cnt == LOAD_AT) begin
            cnt <= '0;
            if (vidx == LAST) begin
              state   <= FIN;
              drive_o <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (fail_mask == '0);
            end else begin
              vidx    <= vidx_nxt;
              drive_o <= next_vec;
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == CMP_AT) begin
              fail_mask <= fail_mask | mism;
              if (mism != '0 && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loopback_tester.sv
// tb/tb_loopback_tester.sv - directed-vector bench for loopback_tester (SETTLE=4 and SETTLE=1 instances)
module tb_loopback_tester;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_a, start_b;
  logic [N-1:0] drive_a, drive_b, sense_a, sense_b;
  logic         busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [N-1:0] mask_a, mask_b;
  logic [15:0]  err_a, err_b;
  int           mode;
  int           applied = 0;
  int           miscompares = 0;

  always #5 clk = ~clk;

  loopback_tester #(.N_CH(N), .SETTLE(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .drive_o(drive_a), .sense_i(sense_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail_mask(mask_a), .err_count(err_a)
  );

  loopback_tester #(.N_CH(N), .SETTLE(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .drive_o(drive_b), .sense_i(sense_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail_mask(mask_b), .err_count(err_b)
  );

  // External wiring model: 0 ideal, 1 channel 3 stuck low, 2 channels 1/2 wired-OR.
  always_comb begin
    sense_a = drive_a;
    sense_b = drive_b;
    if (mode == 1) begin
      sense_a = drive_a & ~8'h08;
      sense_b = drive_b & ~8'h08;
    end else if (mode == 2) begin
      sense_a[1] = drive_a[1] | drive_a[2];
      sense_a[2] = drive_a[1] | drive_a[2];
      sense_b[1] = drive_b[1] | drive_b[2];
      sense_b[2] = drive_b[1] | drive_b[2];
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int which, input int e0, output int edges, output int busy_cycles);
    int e;
    e = e0;
    busy_cycles = 0;
    while (e < 2000) begin
      if ((which == 0) ? done_a : done_b) break;
      if ((which == 0) ? busy_a : busy_b) busy_cycles++;
      step();
      e++;
    end
    edges = e;
  endtask

  task automatic test_reset();
    applied++; if (drive_a !== 8'h00) begin miscompares++; $display("FAIL reset_drive: got %0h expected 0", drive_a); end
    applied++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy_a); end
    applied++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", done_a); end
    applied++; if (pass_a !== 1'b0) begin miscompares++; $display("FAIL reset_pass: got %0b expected 0", pass_a); end
    applied++; if (mask_a !== 8'h00) begin miscompares++; $display("FAIL reset_mask: got %0h expected 0", mask_a); end
    applied++; if (err_a !== 16'd0) begin miscompares++; $display("FAIL reset_err: got %0d expected 0", err_a); end
  endtask

  task automatic test_ideal();
    int edges, bc;
    mode = 0;
    pulse_start(0);
    wait_done(0, 1, edges, bc);
    applied++; if (edges !== 91) begin miscompares++; $display("FAIL ideal_done_edge: got %0d expected 91", edges); end
    applied++; if (bc !== 90) begin miscompares++; $display("FAIL ideal_busy_cycles: got %0d expected 90", bc); end
    applied++; if (pass_a !== 1'b1) begin miscompares++; $display("FAIL ideal_pass: got %0b expected 1", pass_a); end
    applied++; if (mask_a !== 8'h00) begin miscompares++; $display("FAIL ideal_mask: got %0h expected 0", mask_a); end
    applied++; if (err_a !== 16'd0) begin miscompares++; $display("FAIL ideal_err: got %0d expected 0", err_a); end
    applied++; if (drive_a !== 8'h00) begin miscompares++; $display("FAIL ideal_drive_fin: got %0h expected 0", drive_a); end
  endtask

  task automatic test_stuck();
    int edges, bc;
    mode = 1;
    pulse_start(0);
    wait_done(0, 1, edges, bc);
    applied++; if (edges !== 91) begin miscompares++; $display("FAIL stuck_done_edge: got %0d expected 91", edges); end
    applied++; if (mask_a !== 8'h08) begin miscompares++; $display("FAIL stuck_mask: got %0h expected 08", mask_a); end
    applied++; if (err_a !== 16'd9) begin miscompares++; $display("FAIL stuck_err: got %0d expected 9", err_a); end
    applied++; if (pass_a !== 1'b0) begin miscompares++; $display("FAIL stuck_pass: got %0b expected 0", pass_a); end
  endtask

  task automatic test_wired_or();
    int edges, bc;
    mode = 2;
    pulse_start(0);
    wait_done(0, 1, edges, bc);
    applied++; if (mask_a !== 8'h06) begin miscompares++; $display("FAIL wor_mask: got %0h expected 06", mask_a); end
    applied++; if (err_a !== 16'd4) begin miscompares++; $display("FAIL wor_err: got %0d expected 4", err_a); end
    applied++; if (pass_a !== 1'b0) begin miscompares++; $display("FAIL wor_pass: got %0b expected 0", pass_a); end
  endtask

  task automatic test_back_to_back();
    int e, edges, bc;
    mode = 1;
    pulse_start(0);
    e = 1;
    while (e < 19) begin step(); e++; end
    pulse_start(0);
    e++;
    applied++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL b2b_busy_after_ignored: got %0b expected 1", busy_a); end
    while (e < 90) begin step(); e++; end
    applied++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL b2b_done_early: got %0b expected 0 at edge 90", done_a); end
    pulse_start(0);
    e++;
    applied++; if (done_a !== 1'b1) begin miscompares++; $display("FAIL b2b_done_91: got %0b expected 1", done_a); end
    applied++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL b2b_coincident_ignored: busy got %0b expected 0", busy_a); end
    applied++; if (err_a !== 16'd9) begin miscompares++; $display("FAIL b2b_first_err: got %0d expected 9", err_a); end
    pulse_start(0);
    mode = 0;
    applied++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL b2b_restart_busy: got %0b expected 1", busy_a); end
    applied++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL b2b_restart_done: got %0b expected 0", done_a); end
    applied++; if (mask_a !== 8'h00) begin miscompares++; $display("FAIL b2b_restart_mask_clear: got %0h expected 0", mask_a); end
    applied++; if (err_a !== 16'd0) begin miscompares++; $display("FAIL b2b_restart_err_clear: got %0d expected 0", err_a); end
    wait_done(0, 1, edges, bc);
    applied++; if (edges !== 91) begin miscompares++; $display("FAIL b2b_second_done_edge: got %0d expected 91", edges); end
    applied++; if (pass_a !== 1'b1) begin miscompares++; $display("FAIL b2b_second_pass: got %0b expected 1", pass_a); end
  endtask

  task automatic test_reset_mid_run();
    int e, edges, bc;
    mode = 1;
    pulse_start(0);
    e = 1;
    while (e < 40) begin step(); e++; end
    applied++; if (mask_a !== 8'h08) begin miscompares++; $display("FAIL rst_mid_mask_before: got %0h expected 08", mask_a); end
    rst_n = 1'b0;
    #1;
    applied++; if (drive_a !== 8'h00) begin miscompares++; $display("FAIL rst_mid_drive: got %0h expected 0", drive_a); end
    applied++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %0b expected 0", busy_a); end
    applied++; if (mask_a !== 8'h00) begin miscompares++; $display("FAIL rst_mid_mask: got %0h expected 0", mask_a); end
    applied++; if (err_a !== 16'd0) begin miscompares++; $display("FAIL rst_mid_err: got %0d expected 0", err_a); end
    applied++; if (done_a !== 1'b0 || pass_a !== 1'b0) begin miscompares++; $display("FAIL rst_mid_done_pass: got %0b%0b expected 00", done_a, pass_a); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step();
    applied++; if (busy_a !== 1'b0 || drive_a !== 8'h00) begin miscompares++; $display("FAIL rst_mid_idle: busy %0b drive %0h expected 0/0", busy_a, drive_a); end
    mode = 0;
    pulse_start(0);
    wait_done(0, 1, edges, bc);
    applied++; if (edges !== 91 || pass_a !== 1'b1) begin miscompares++; $display("FAIL rst_mid_rerun: edge %0d pass %0b expected 91/1", edges, pass_a); end
  endtask

  task automatic test_settle_min();
    int edges, bc;
    mode = 0;
    pulse_start(1);
    wait_done(1, 1, edges, bc);
    applied++; if (edges !== 73) begin miscompares++; $display("FAIL settle1_done_edge: got %0d expected 73", edges); end
    applied++; if (bc !== 72) begin miscompares++; $display("FAIL settle1_busy_cycles: got %0d expected 72", bc); end
    applied++; if (pass_b !== 1'b1 || mask_b !== 8'h00) begin miscompares++; $display("FAIL settle1_ideal: pass %0b mask %0h expected 1/00", pass_b, mask_b); end
    mode = 1;
    pulse_start(1);
    wait_done(1, 1, edges, bc);
    applied++; if (mask_b !== 8'h08) begin miscompares++; $display("FAIL settle1_stuck_mask: got %0h expected 08", mask_b); end
    applied++; if (err_b !== 16'd9) begin miscompares++; $display("FAIL settle1_stuck_err: got %0d expected 9", err_b); end
    mode = 2;
    pulse_start(1);
    wait_done(1, 1, edges, bc);
    applied++; if (mask_b !== 8'h06 || err_b !== 16'd4) begin miscompares++; $display("FAIL settle1_wor: mask %0h err %0d expected 06/4", mask_b, err_b); end
  endtask

  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    mode    = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) step();
    test_reset();
    test_ideal();
    test_stuck();
    test_wired_or();
    test_back_to_back();
    test_reset_mid_run();
    test_settle_min();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
